// File: rtl/game_pkg.sv
// Shared types and constants for the sudoku game sequencer.
package game_pkg;
  localparam int GAME_MAX_N  = 9;
  localparam int GAME_ADDR_W = 7;
  localparam int CELL_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_SCAN_ROW,
    ST_SCAN_COL,
    ST_SCAN_BOX,
    ST_WIN
  } game_state_t;
endpackage

// File: rtl/group_dup_checker.sv
// Per-group duplicate / range / emptiness accumulator over one scan.
// Outputs already include the datum presented this cycle.
module group_dup_checker
  import game_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_all,
  input  logic              clr_group,
  input  logic              valid,
  input  logic [CELL_W-1:0] value,
  input  logic [3:0]        n_digits,
  output logic              conflict,
  output logic              full
);
  logic [8:0] r_seen;
  logic       r_conflict;
  logic       r_full;

  logic [8:0] w_seen_base;
  logic [8:0] w_bit;
  logic       w_in_range;
  logic       w_dup;
  logic       w_over;
  logic       w_empty;

  always_comb begin
    w_seen_base = clr_group ? 9'd0 : r_seen;
    w_in_range  = (value != 4'd0) && (value <= n_digits);
    w_bit       = w_in_range ? (9'd1 << (value - 4'd1)) : 9'd0;
    w_dup       = valid && ((w_seen_base & w_bit) != 9'd0);
    w_over      = valid && (value > n_digits);
    w_empty     = valid && (value == 4'd0);
    conflict    = r_conflict | w_dup | w_over;
    full        = r_full & ~w_empty;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      r_seen     <= 9'd0;
      r_conflict <= 1'b0;
      r_full     <= 1'b1;
    end else if (valid) begin
      r_seen     <= w_seen_base | w_bit;
      r_conflict <= conflict;
      r_full     <= full;
    end
  end
endmodule

// File: rtl/sudoku_game_ctrl.sv
// Game FSM plus row/column/box scanner of the cell RAM producing incorrect/victory.
// Address stage and one-cycle data-align stage feed the group checker.
module sudoku_game_ctrl
  import game_pkg::*;
#(
  parameter int MAX_N  = GAME_MAX_N,
  parameter int ADDR_W = GAME_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        size_sel,
  input  logic              quit,
  input  logic              cell_we,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CELL_W-1:0] rd_data,
  output logic              is_game_on,
  output logic [2:0]        board_size,
  output logic              incorrect,
  output logic              victory,
  output logic              busy
);
  game_state_t r_state, w_next;

  logic [2:0]        r_board_size;
  logic [3:0]        r_g, r_e;
  logic [1:0]        r_br, r_bc, r_er, r_ec;
  logic              r_issue_done;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_addr_vld, r_addr_first, r_addr_last;
  logic              r_chk_vld, r_chk_first, r_chk_last;
  logic              r_pending, r_incorrect, r_victory, r_busy, r_is_game_on;

  logic [3:0]        w_n_grp;
  logic [1:0]        w_n_m1;
  logic              w_scanning, w_issue, w_grp_end, w_pass_end;
  logic              w_ec_end, w_er_end, w_bc_end, w_br_end, w_first, w_last;
  logic [3:0]        w_row, w_col;
  logic [ADDR_W-1:0] w_addr;
  logic              w_done, w_start_ok, w_quit, w_restart, w_scan_start;
  logic              w_conflict, w_full;

  assign w_n_grp    = (r_board_size == 3'd2) ? 4'd4 : 4'd9;
  assign w_n_m1     = (r_board_size == 3'd2) ? 2'd1 : 2'd2;
  assign w_scanning = (r_state == ST_SCAN_ROW) || (r_state == ST_SCAN_COL) ||
                      (r_state == ST_SCAN_BOX);
  assign w_issue    = w_scanning && !r_issue_done;
  assign w_grp_end  = (r_e == w_n_grp - 4'd1);
  assign w_pass_end = w_grp_end && (r_g == w_n_grp - 4'd1);
  assign w_ec_end   = (r_ec == w_n_m1);
  assign w_er_end   = (r_er == w_n_m1);
  assign w_bc_end   = (r_bc == w_n_m1);
  assign w_br_end   = (r_br == w_n_m1);
  assign w_done     = r_chk_vld && r_chk_last;
  assign w_start_ok = start && ((size_sel == 3'd2) || (size_sel == 3'd3));
  assign w_quit     = quit && (r_state != ST_IDLE);
  assign w_restart  = r_pending || cell_we;
  assign w_scan_start = (w_next == ST_SCAN_ROW) && (r_state != ST_SCAN_ROW);

  // Box pass walks box-row, box-col, elem-row, elem-col so no division is needed.
  always_comb begin
    w_row   = r_g;
    w_col   = r_e;
    w_first = (r_e == 4'd0);
    w_last  = 1'b0;
    case (r_state)
      ST_SCAN_COL: begin
        w_row = r_e;
        w_col = r_g;
      end
      ST_SCAN_BOX: begin
        w_row   = 4'(r_br) * 4'(r_board_size) + 4'(r_er);
        w_col   = 4'(r_bc) * 4'(r_board_size) + 4'(r_ec);
        w_first = (r_er == 2'd0) && (r_ec == 2'd0);
        w_last  = w_ec_end && w_er_end && w_bc_end && w_br_end;
      end
      default: ;
    endcase
    w_addr = ADDR_W'(w_row) * ADDR_W'(MAX_N) + ADDR_W'(w_col);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_start_ok) w_next = ST_SCAN_ROW;
      ST_PLAY:     if (cell_we) w_next = ST_SCAN_ROW;
      ST_SCAN_ROW: if (w_issue && w_pass_end) w_next = ST_SCAN_COL;
      ST_SCAN_COL: if (w_issue && w_pass_end) w_next = ST_SCAN_BOX;
      ST_SCAN_BOX: begin
        if (w_done) begin
          if (w_restart)                 w_next = ST_SCAN_ROW;
          else if (w_full && !w_conflict) w_next = ST_WIN;
          else                           w_next = ST_PLAY;
        end
      end
      ST_WIN:      ;
      default:     w_next = ST_IDLE;
    endcase
    if (w_quit) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst || w_scan_start || w_quit) begin
      r_g <= 4'd0;  r_e <= 4'd0;
      r_br <= 2'd0; r_bc <= 2'd0; r_er <= 2'd0; r_ec <= 2'd0;
      r_issue_done <= 1'b0;
    end else if (w_issue) begin
      if (r_state == ST_SCAN_BOX) begin
        if (w_ec_end) begin
          r_ec <= 2'd0;
          if (w_er_end) begin
            r_er <= 2'd0;
            if (w_bc_end) begin
              r_bc <= 2'd0;
              if (w_br_end) begin
                r_br         <= 2'd0;
                r_issue_done <= 1'b1;
              end else r_br <= r_br + 2'd1;
            end else r_bc <= r_bc + 2'd1;
          end else r_er <= r_er + 2'd1;
        end else r_ec <= r_ec + 2'd1;
      end else if (w_grp_end) begin
        r_e <= 4'd0;
        r_g <= w_pass_end ? 4'd0 : r_g + 4'd1;
      end else begin
        r_e <= r_e + 4'd1;
      end
    end
  end

  // RAM data lags the address by one clock; valid/first/last follow it.
  always_ff @(posedge clk) begin
    if (rst || w_quit) begin
      r_addr_vld <= 1'b0; r_addr_first <= 1'b0; r_addr_last <= 1'b0;
      r_chk_vld  <= 1'b0; r_chk_first  <= 1'b0; r_chk_last  <= 1'b0;
    end else begin
      r_addr_vld   <= w_issue;
      r_addr_first <= w_issue && w_first;
      r_addr_last  <= w_issue && w_last;
      r_chk_vld    <= r_addr_vld;
      r_chk_first  <= r_addr_first;
      r_chk_last   <= r_addr_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          r_rd_addr <= '0;
    else if (w_issue) r_rd_addr <= w_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_board_size <= 3'd3;
      r_is_game_on <= 1'b0;
      r_busy       <= 1'b0;
      r_incorrect  <= 1'b0;
      r_victory    <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      r_is_game_on <= (w_next != ST_IDLE);
      r_busy       <= w_scanning && !w_done && !w_quit;
      if (w_quit) begin
        r_incorrect <= 1'b0;
        r_victory   <= 1'b0;
        r_pending   <= 1'b0;
      end else if (w_done) begin
        r_incorrect <= w_conflict;
        r_victory   <= w_full && !w_conflict;
        r_pending   <= 1'b0;
      end else if ((r_state == ST_IDLE) && w_start_ok) begin
        r_board_size <= size_sel;
        r_incorrect  <= 1'b0;
        r_victory    <= 1'b0;
      end else if (w_scanning && cell_we) begin
        r_pending <= 1'b1;
      end
    end
  end

  group_dup_checker u_checker (
    .clk       (clk),
    .rst       (rst),
    .clr_all   (w_scan_start),
    .clr_group (r_chk_first),
    .valid     (r_chk_vld),
    .value     (rd_data),
    .n_digits  (w_n_grp),
    .conflict  (w_conflict),
    .full      (w_full)
  );

  assign rd_addr    = r_rd_addr;
  assign is_game_on = r_is_game_on;
  assign board_size = r_board_size;
  assign incorrect  = r_incorrect;
  assign victory    = r_victory;
  assign busy       = r_busy;
endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Bench for sudoku_game_ctrl: RAM model plus a board-rule reference model.
module tb_sudoku_game_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, quit, cell_we;
  logic [2:0] size_sel;
  logic [6:0] rd_addr;
  logic [3:0] rd_data;
  logic       is_game_on, incorrect, victory, busy;
  logic [2:0] board_size;

  logic [3:0] mem [0:127];
  int checks = 0;
  int errors = 0;
  bit cur_inc, cur_vic, in_win, game_on;
  int cur_n;

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr];

  sudoku_game_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .size_sel(size_sel), .quit(quit),
    .cell_we(cell_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .is_game_on(is_game_on), .board_size(board_size), .incorrect(incorrect),
    .victory(victory), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cell address visited at (pass, group, element) per the game rules.
  function automatic int cell_addr(int n, int p, int g, int e);
    int r, c;
    if (p == 0)      begin r = g; c = e; end
    else if (p == 1) begin r = e; c = g; end
    else begin r = (g / n) * n + e / n; c = (g % n) * n + e % n; end
    return r * 9 + c;
  endfunction

  function automatic int exp_addr(int n, int k);
    int nn = n * n;
    return cell_addr(n, k / (nn * nn), (k % (nn * nn)) / nn, k % nn);
  endfunction

  task automatic model_flags(input int n, output bit inc, output bit vic);
    int nn = n * n;
    bit conflict = 0;
    bit full = 1;
    for (int p = 0; p < 3; p++)
      for (int g = 0; g < nn; g++) begin
        bit seen [16];
        for (int i = 0; i < 16; i++) seen[i] = 0;
        for (int e = 0; e < nn; e++) begin
          int v = int'(mem[cell_addr(n, p, g, e)]);
          if (v == 0) full = 0;
          else if (v > nn) conflict = 1;
          else if (seen[v]) conflict = 1;
          else seen[v] = 1;
        end
      end
    inc = conflict;
    vic = full && !conflict;
  endtask

  task automatic fill_junk();
    for (int a = 0; a < 128; a++) mem[a] = 4'($urandom_range(1, 15));
  endtask

  task automatic fill_solved(input int n);
    int nn = n * n;
    int perm [9];
    fill_junk();
    for (int i = 0; i < 9; i++) perm[i] = i + 1;
    for (int i = nn - 1; i > 0; i--) begin
      int j = $urandom_range(0, i);
      int t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int r = 0; r < nn; r++)
      for (int c = 0; c < nn; c++)
        mem[r * 9 + c] = 4'(perm[(r * n + r / n + c) % nn]);
  endtask

  task automatic pulse_start(input logic [2:0] s);
    @(negedge clk); start = 1'b1; size_sel = s;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic start_game(input int n);
    pulse_start(3'(n));
    game_on = 1; cur_inc = 0; cur_vic = 0; cur_n = n;
  endtask

  task automatic pulse_we();
    @(negedge clk); cell_we = 1'b1;
    @(posedge clk); #1; cell_we = 1'b0;
  endtask

  task automatic do_quit(input string tag);
    @(negedge clk); quit = 1'b1;
    @(posedge clk); #1; quit = 1'b0;
    @(negedge clk);
    chk({tag, "_on"}, 32'(is_game_on), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_inc"}, 32'(incorrect), 0);
    chk({tag, "_vic"}, 32'(victory), 0);
    game_on = 0; cur_inc = 0; cur_vic = 0; in_win = 0;
  endtask

  // Called just after the trigger edge t; returns after edge t+3N^2+2.
  task automatic check_scan(input int n, input string tag);
    bit einc, evic;
    int nn = n * n;
    model_flags(n, einc, evic);
    for (int k = 0; k < 3 * nn * nn; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 0) begin
        chk({tag, "_busy_rise"}, 32'(busy), 1);
        chk({tag, "_inc_hold0"}, 32'(incorrect), 32'(cur_inc));
      end
      chk({tag, "_addr"}, 32'(rd_addr), 32'(exp_addr(n, k)));
    end
    @(posedge clk); @(negedge clk);
    chk({tag, "_busy_last"}, 32'(busy), 1);
    chk({tag, "_inc_hold"}, 32'(incorrect), 32'(cur_inc));
    chk({tag, "_vic_hold"}, 32'(victory), 32'(cur_vic));
    @(posedge clk); @(negedge clk);
    chk({tag, "_busy_fall"}, 32'(busy), 0);
    chk({tag, "_inc"}, 32'(incorrect), 32'(einc));
    chk({tag, "_vic"}, 32'(victory), 32'(evic));
    cur_inc = einc; cur_vic = evic; in_win = evic;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; quit = 1'b0; cell_we = 1'b0; size_sel = 3'd0;
    game_on = 0; in_win = 0; cur_inc = 0; cur_vic = 0; cur_n = 3;
    fill_junk();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_on", 32'(is_game_on), 0);
    chk("rst_size", 32'(board_size), 3);
    chk("rst_inc", 32'(incorrect), 0);
    chk("rst_vic", 32'(victory), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    rst = 1'b0;

    // Unsupported size is ignored in IDLE.
    pulse_start(3'd4);
    repeat (3) @(negedge clk);
    chk("bad_size", 32'(board_size), 3);
    chk("bad_on", 32'(is_game_on), 0);
    chk("bad_busy", 32'(busy), 0);

    // Solved 9x9 wins; WIN ignores cell_we.
    fill_solved(3);
    start_game(3);
    check_scan(3, "solved9");
    chk("solved9_on", 32'(is_game_on), 1);
    chk("solved9_vic1", 32'(victory), 1);
    pulse_we();
    repeat (4) @(negedge clk);
    chk("win_we_busy", 32'(busy), 0);
    chk("win_we_vic", 32'(victory), 1);
    do_quit("quit_win");

    // 4x4 with one hole: no conflict, no victory.
    fill_solved(2);
    mem[$urandom_range(0, 3) * 9 + $urandom_range(0, 3)] = 4'd0;
    start_game(2);
    check_scan(2, "hole4");
    chk("hole4_size", 32'(board_size), 2);
    chk("hole4_inc0", 32'(incorrect), 0);
    chk("hole4_vic0", 32'(victory), 0);
    do_quit("quit_hole");

    // Directed duplicates on a mostly empty 9x9 board.
    for (int a = 0; a < 81; a++) mem[a] = 4'd0;
    mem[0] = 4'd5; mem[1] = 4'd5;
    start_game(3);
    check_scan(3, "rowdup");
    chk("rowdup_inc1", 32'(incorrect), 1);
    mem[1] = 4'd6;
    pulse_we();
    check_scan(3, "rowfix");
    chk("rowfix_inc0", 32'(incorrect), 0);
    pulse_start(3'd2);
    repeat (3) @(negedge clk);
    chk("play_start_size", 32'(board_size), 3);
    chk("play_start_busy", 32'(busy), 0);
    mem[1] = 4'd0; mem[27] = 4'd5;
    pulse_we();
    check_scan(3, "coldup");
    chk("coldup_inc1", 32'(incorrect), 1);
    mem[27] = 4'd0;
    pulse_we();
    check_scan(3, "colfix");
    mem[10] = 4'd5;
    pulse_we();
    check_scan(3, "boxdup");
    chk("boxdup_inc1", 32'(incorrect), 1);
    mem[10] = 4'd0;
    pulse_we();
    check_scan(3, "boxfix");
    chk("boxfix_inc0", 32'(incorrect), 0);

    // Randomized boards, both sizes, with random corruptions.
    for (int round = 0; round < 8; round++) begin
      int n = $urandom_range(2, 3);
      int k = $urandom_range(0, 3);
      fill_solved(n);
      for (int i = 0; i < k; i++)
        mem[$urandom_range(0, n * n - 1) * 9 + $urandom_range(0, n * n - 1)] =
          4'($urandom_range(0, 15));
      if (!game_on) start_game(n);
      else if (in_win || cur_n != n) begin
        do_quit("rand_quit");
        start_game(n);
      end else pulse_we();
      check_scan(n, "rand");
    end

    // cell_we mid-scan: first scan reports the old board, second the new.
    do_quit("pre_mid");
    fill_solved(3);
    begin
      logic [3:0] t;
      t = mem[0]; mem[0] = mem[1]; mem[1] = t;
      start_game(3);
      repeat (2 * 81 + 4) @(posedge clk);
      @(negedge clk);
      t = mem[0]; mem[0] = mem[1]; mem[1] = t;
      cell_we = 1'b1;
      @(posedge clk); #1; cell_we = 1'b0;
    end
    repeat (81 - 3) @(posedge clk);
    @(negedge clk);
    chk("mid1_busy", 32'(busy), 0);
    chk("mid1_inc", 32'(incorrect), 1);
    chk("mid1_vic", 32'(victory), 0);
    cur_inc = 1; cur_vic = 0;
    check_scan(3, "mid2");
    chk("mid2_vic1", 32'(victory), 1);

    // quit during the column pass abandons the scan.
    do_quit("pre_q");
    fill_solved(3);
    mem[1] = mem[0];
    start_game(3);
    check_scan(3, "qdup");
    pulse_we();
    repeat (81 + 5) @(posedge clk);
    do_quit("quit_col");
    pulse_we();
    repeat (5) @(negedge clk);
    chk("after_quit_busy", 32'(busy), 0);
    repeat (250) @(posedge clk);
    @(negedge clk);
    chk("after_quit_busy2", 32'(busy), 0);
    chk("after_quit_on", 32'(is_game_on), 0);
    chk("after_quit_inc", 32'(incorrect), 0);
    chk("after_quit_size", 32'(board_size), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
